// File: rtl/memory_stage_if.sv
// ----------------------------------------------------------------------------
// memory_stage_if
//
// Half-word SRAM bus between the pipeline memory stage and the external
// 16-bit SRAM.
//
//   sramAddress      18  half-word address            (master -> slave)
//   sramDataOut      16  write data                   (master -> slave)
//   sramDataOe        1  master drives the data bus   (master -> slave)
//   sramWriteEnableN  1  active-low write strobe      (master -> slave)
//   sramDataIn       16  read data                    (slave  -> master)
//
// master: the memory stage.  slave: the SRAM (or its model).
// ----------------------------------------------------------------------------
interface memory_stage_if;
    logic [17:0] sramAddress;
    logic [15:0] sramDataOut;
    logic        sramDataOe;
    logic        sramWriteEnableN;
    logic [15:0] sramDataIn;

    modport master (
        output sramAddress,
        output sramDataOut,
        output sramDataOe,
        output sramWriteEnableN,
        input  sramDataIn
    );

    modport slave (
        input  sramAddress,
        input  sramDataOut,
        input  sramDataOe,
        input  sramWriteEnableN,
        output sramDataIn
    );
endinterface

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
//
// Memory-access stage of the five-stage pipeline.  Loads and stores a 32-bit
// word as two half-word accesses (low half, then high half) on a 16-bit SRAM,
// each half holding the bus for WAIT_CYCLES cycles.  While an access is in
// flight `ready` is low so the hazard logic freezes every upstream stage.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   writebackEnabled         in  : from execution-stage register
//   memoryReadEnabled        in  : load request
//   memoryWriteEnabled       in  : store request
//   aluResult                in  : byte address for loads/stores, else result
//   valRm                    in  : store data
//   destination              in  : destination register index
//   writebackEnabledOut      out : gated by ready
//   memoryReadEnabledOut     out : gated by ready
//   aluResultOut             out : pass-through
//   memoryData               out : last assembled load word
//   destinationOut           out : pass-through
//   ready                    out : 0 = freeze the pipeline
//   sram                     SRAM bus (master side)
// ----------------------------------------------------------------------------
module memory_stage #(
    parameter int unsigned WAIT_CYCLES  = 2,
    parameter int unsigned BASE_ADDRESS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writebackEnabled,
    input  logic                  memoryReadEnabled,
    input  logic                  memoryWriteEnabled,
    input  logic [31:0]           aluResult,
    input  logic [31:0]           valRm,
    input  logic [3:0]            destination,
    output logic                  writebackEnabledOut,
    output logic                  memoryReadEnabledOut,
    output logic [31:0]           aluResultOut,
    output logic [31:0]           memoryData,
    output logic [3:0]            destinationOut,
    output logic                  ready,
    memory_stage_if.master        sram
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOW  = 2'd1;
    localparam logic [1:0] ST_HIGH = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int CNT_W = ($clog2(WAIT_CYCLES) > 2) ? $clog2(WAIT_CYCLES) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      read_data_q, read_data_d;

    logic             req_s;
    logic             is_read_s;
    logic             is_write_s;
    logic [16:0]      word_index_s;
    logic [1:0]       phase_s;
    logic [CNT_W-1:0] phase_cnt_s;
    logic             last_s;
    logic             write_phase_s;

    // Request decode; a read wins when both enables are set.
    assign req_s        = memoryReadEnabled | memoryWriteEnabled;
    assign is_read_s    = memoryReadEnabled;
    assign is_write_s   = memoryWriteEnabled & ~memoryReadEnabled;
    assign word_index_s = 17'((aluResult - BASE_ADDRESS) >> 2);

    // Effective bus phase: the IDLE cycle in which a request is first seen is
    // already the first LOW cycle, so a half-word occupies exactly
    // WAIT_CYCLES cycles and the access has no dead bus cycle up front.
    // Reset suppresses it so the bus is released immediately.
    always_comb begin
        if ((state_q == ST_IDLE) && req_s && !rst) begin
            phase_s     = ST_LOW;
            phase_cnt_s = '0;
        end else begin
            phase_s     = state_q;
            phase_cnt_s = cnt_q;
        end
    end

    assign last_s = (phase_cnt_s == CNT_LAST);

    // Next-state, phase counter and load-word capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        read_data_d = read_data_q;
        case (phase_s)
            ST_LOW, ST_HIGH: begin
                if (last_s) begin
                    cnt_d   = '0;
                    state_d = (phase_s == ST_LOW) ? ST_HIGH : ST_DONE;
                    if (is_read_s) begin
                        if (phase_s == ST_LOW) begin
                            read_data_d[15:0] = sram.sramDataIn;
                        end else begin
                            read_data_d[31:16] = sram.sramDataIn;
                        end
                    end else begin
                        read_data_d = read_data_q;
                    end
                end else begin
                    cnt_d   = phase_cnt_s + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = phase_s;
                end
            end
            // DONE returns to IDLE without looking at req: the inputs still
            // belong to the access that has just completed.
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            read_data_q <= read_data_d;
        end
    end

    // ready: high when idle with no request, and for the single DONE cycle.
    always_comb begin
        if (state_q == ST_DONE) begin
            ready = 1'b1;
        end else if (state_q == ST_IDLE) begin
            ready = ~req_s;
        end else begin
            ready = 1'b0;
        end
    end

    assign write_phase_s = is_write_s & ((phase_s == ST_LOW) | (phase_s == ST_HIGH));

    // SRAM bus drive.
    always_comb begin
        case (phase_s)
            ST_LOW:  sram.sramAddress = {word_index_s, 1'b0};
            ST_HIGH: sram.sramAddress = {word_index_s, 1'b1};
            default: sram.sramAddress = 18'd0;
        endcase
        if (write_phase_s) begin
            sram.sramDataOe       = 1'b1;
            sram.sramWriteEnableN = 1'b0;
            sram.sramDataOut      = (phase_s == ST_HIGH) ? valRm[31:16] : valRm[15:0];
        end else begin
            sram.sramDataOe       = 1'b0;
            sram.sramWriteEnableN = 1'b1;
            sram.sramDataOut      = 16'd0;
        end
    end

    assign writebackEnabledOut  = writebackEnabled & ready;
    assign memoryReadEnabledOut = memoryReadEnabled & ready;
    assign aluResultOut         = aluResult;
    assign destinationOut       = destination;
    assign memoryData           = read_data_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_i = 1'b0, rd_i = 1'b0, wr_i = 1'b0;
    logic [31:0] alu_i = 32'd0, val_i = 32'd0;
    logic [3:0]  dest_i = 4'd0;
    logic        wb_o, rd_o, ready;
    logic [31:0] alu_o, md_o;
    logic [3:0]  dest_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    memory_stage_if sram_bus();

    memory_stage #(.WAIT_CYCLES(W), .BASE_ADDRESS(1024)) dut (
        .clk(clk), .rst(rst),
        .writebackEnabled(wb_i), .memoryReadEnabled(rd_i), .memoryWriteEnabled(wr_i),
        .aluResult(alu_i), .valRm(val_i), .destination(dest_i),
        .writebackEnabledOut(wb_o), .memoryReadEnabledOut(rd_o),
        .aluResultOut(alu_o), .memoryData(md_o), .destinationOut(dest_o),
        .ready(ready), .sram(sram_bus)
    );

    // ---------------- SRAM model (256 half-words) ----------------
    function automatic logic [31:0] init_word(input int w);
        return {16'hC000 + 16'(w), 16'h3000 + 16'(w)};
    endfunction

    logic [15:0] sram [256];
    logic        mem_init = 1'b1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int w = 0; w < 128; w++) begin
                sram[2*w]   <= init_word(w) >> 0;
                sram[2*w+1] <= init_word(w) >> 16;
            end
        end else if (!sram_bus.sramWriteEnableN && sram_bus.sramDataOe) begin
            sram[sram_bus.sramAddress[7:0]] <= sram_bus.sramDataOut;
        end
    end

    assign sram_bus.sramDataIn = sram[sram_bus.sramAddress[7:0]];

    // ---------------- Reference word memory ----------------
    logic [31:0] ref_mem [64];

    // ---------------- Checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Per-cycle log of observed outputs for the hand-written sequences.
    logic        rdy_l  [24];
    logic [17:0] addr_l [24];
    logic [15:0] dout_l [24];
    logic        wen_l  [24];
    logic        oe_l   [24];
    logic        wbo_l  [24];
    logic [31:0] md_l   [24];
    int          log_n;

    task automatic log_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rdy_l[log_n]  = ready;
            addr_l[log_n] = sram_bus.sramAddress;
            dout_l[log_n] = sram_bus.sramDataOut;
            wen_l[log_n]  = sram_bus.sramWriteEnableN;
            oe_l[log_n]   = sram_bus.sramDataOe;
            wbo_l[log_n]  = wb_o;
            md_l[log_n]   = md_o;
            log_n++;
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic wb,
                         input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest);
        @(posedge clk);
        #1;
        rd_i = rd; wr_i = wr; wb_i = wb; alu_i = alu; val_i = val; dest_i = dest;
    endtask

    // Runs one instruction; returns stall cycles and DONE-cycle observations.
    task automatic run_access(input logic rd, input logic wr, input logic wb,
                              input logic [31:0] alu, input logic [31:0] val, input logic [3:0] dest,
                              output int stall, output logic [31:0] data,
                              output logic wbo_done, output logic rdo_done, output logic bad_gate);
        drive(rd, wr, wb, alu, val, dest);
        stall = 0;
        bad_gate = 1'b0;
        @(negedge clk);
        while (ready !== 1'b1 && stall < 20) begin
            if (wb_o !== 1'b0 || rd_o !== 1'b0) bad_gate = 1'b1;
            stall++;
            @(negedge clk);
        end
        data     = md_o;
        wbo_done = wb_o;
        rdo_done = rd_o;
    endtask

    // Expected bus pattern for a store of 0xDEADBEEF at word 2.
    localparam logic [17:0] ST_ADDR [5] = '{18'd4, 18'd4, 18'd5, 18'd5, 18'd0};
    localparam logic [15:0] ST_DOUT [5] = '{16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0000};
    localparam logic        ST_WEN  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        ACC_RDY [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    typedef struct {
        logic        wb;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic        e_ready;
        logic        e_wbo;
        logic [31:0] e_alu;
        logic [3:0]  e_dest;
    } vec_t;

    initial begin
        vec_t vecs [4];
        int stall;
        logic [31:0] data;
        logic wbo_d, rdo_d, bad;

        for (int w = 0; w < 64; w++) ref_mem[w] = init_word(w);

        vecs[0] = '{wb: 1'b1, alu: 32'h0000_1234, dest: 4'd3, e_ready: 1'b1, e_wbo: 1'b1, e_alu: 32'h0000_1234, e_dest: 4'd3};
        vecs[1] = '{wb: 1'b0, alu: 32'hFFFF_FFFF, dest: 4'd15, e_ready: 1'b1, e_wbo: 1'b0, e_alu: 32'hFFFF_FFFF, e_dest: 4'd15};
        vecs[2] = '{wb: 1'b1, alu: 32'h0000_0400, dest: 4'd0, e_ready: 1'b1, e_wbo: 1'b1, e_alu: 32'h0000_0400, e_dest: 4'd0};
        vecs[3] = '{wb: 1'b1, alu: 32'h8000_0001, dest: 4'd9, e_ready: 1'b1, e_wbo: 1'b1, e_alu: 32'h8000_0001, e_dest: 4'd9};

        // ---- reset state ----
        @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_addr",  32'(sram_bus.sramAddress), 32'd0);
        chk("reset_wen",   32'(sram_bus.sramWriteEnableN), 32'd1);
        chk("reset_oe",    32'(sram_bus.sramDataOe), 32'd0);
        chk("reset_dout",  32'(sram_bus.sramDataOut), 32'd0);
        chk("reset_mdata", md_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_init = 1'b0;

        // ---- non-memory vectors ----
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, vecs[i].wb, vecs[i].alu, 32'd0, vecs[i].dest);
            @(negedge clk);
            chk($sformatf("nonmem_ready[%0d]", i), 32'(ready), 32'(vecs[i].e_ready));
            chk($sformatf("nonmem_wbo[%0d]", i), 32'(wb_o), 32'(vecs[i].e_wbo));
            chk($sformatf("nonmem_alu[%0d]", i), alu_o, vecs[i].e_alu);
            chk($sformatf("nonmem_dest[%0d]", i), 32'(dest_o), 32'(vecs[i].e_dest));
            chk($sformatf("nonmem_wen[%0d]", i), 32'(sram_bus.sramWriteEnableN), 32'd1);
            chk($sformatf("nonmem_addr[%0d]", i), 32'(sram_bus.sramAddress), 32'd0);
        end

        // ---- store 0xDEADBEEF at 1032 ----
        log_n = 0;
        drive(1'b0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 4'd1);
        log_cycles(5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("store_ready[%0d]", i), 32'(rdy_l[i]), 32'(ACC_RDY[i]));
            chk($sformatf("store_addr[%0d]", i), 32'(addr_l[i]), 32'(ST_ADDR[i]));
            chk($sformatf("store_dout[%0d]", i), 32'(dout_l[i]), 32'(ST_DOUT[i]));
            chk($sformatf("store_wen[%0d]", i), 32'(wen_l[i]), 32'(ST_WEN[i]));
            chk($sformatf("store_oe[%0d]", i), 32'(oe_l[i]), 32'(!ST_WEN[i]));
        end

        // ---- load from 1032 ----
        log_n = 0;
        drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd2);
        log_cycles(5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("load_ready[%0d]", i), 32'(rdy_l[i]), 32'(ACC_RDY[i]));
            chk($sformatf("load_wbo[%0d]", i), 32'(wbo_l[i]), 32'(ACC_RDY[i]));
            chk($sformatf("load_wen[%0d]", i), 32'(wen_l[i]), 32'd1);
        end
        chk("load_mdata_done", md_l[4], 32'hDEADBEEF);

        // ---- back-to-back: load 1032 then store 1028 ----
        log_n = 0;
        drive(1'b1, 1'b0, 1'b1, 32'd1032, 32'd0, 4'd2);
        log_cycles(5);
        drive(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0BADF00D, 4'd3);
        log_cycles(5);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("b2b_ready[%0d]", i), 32'(rdy_l[i]), 32'(ACC_RDY[i % 5]));
        end
        chk("b2b_load_mdata", md_l[4], 32'hDEADBEEF);
        chk("b2b_store_start_addr", 32'(addr_l[5]), 32'd2);
        chk("b2b_store_start_wen", 32'(wen_l[5]), 32'd0);
        chk("b2b_store_high_dout", 32'(dout_l[7]), 32'h0BAD);
        ref_mem[1] = 32'h0BADF00D;

        // ---- reset during the HIGH phase of a store ----
        drive(1'b0, 1'b1, 1'b0, 32'd1064, 32'h12345678, 4'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_wen", 32'(sram_bus.sramWriteEnableN), 32'd0);
        chk("rst_pre_addr", 32'(sram_bus.sramAddress), 32'd21);
        rst = 1'b1;
        #1;
        chk("rst_wen", 32'(sram_bus.sramWriteEnableN), 32'd1);
        chk("rst_oe", 32'(sram_bus.sramDataOe), 32'd0);
        chk("rst_addr", 32'(sram_bus.sramAddress), 32'd0);
        chk("rst_mdata", md_o, 32'd0);
        chk("rst_ready_req", 32'(ready), 32'd0);
        wr_i = 1'b0;
        #1;
        chk("rst_ready_noreq", 32'(ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);
        chk("post_rst_addr", 32'(sram_bus.sramAddress), 32'd0);

        // ---- both enables: read wins, no write strobe ----
        log_n = 0;
        drive(1'b1, 1'b1, 1'b1, 32'd1032, 32'hFFFF_FFFF, 4'd5);
        log_cycles(5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("both_wen[%0d]", i), 32'(wen_l[i]), 32'd1);
            chk($sformatf("both_oe[%0d]", i), 32'(oe_l[i]), 32'd0);
            chk($sformatf("both_ready[%0d]", i), 32'(rdy_l[i]), 32'(ACC_RDY[i]));
            chk($sformatf("both_addr[%0d]", i), 32'(addr_l[i]), 32'(ST_ADDR[i]));
        end
        chk("both_mdata", md_l[4], 32'hDEADBEEF);

        // ---- randomized instruction stream vs. reference memory ----
        for (int t = 0; t < 40; t++) begin
            int kind, idx;
            logic wb;
            logic [31:0] alu, val;
            logic [3:0] dest;
            kind = $urandom_range(0, 2);
            idx  = $urandom_range(16, 63);
            wb   = 1'($urandom_range(0, 1));
            val  = $urandom;
            dest = 4'($urandom_range(0, 15));
            alu  = (kind == 0) ? $urandom : 32'(1024 + idx * 4 + $urandom_range(0, 3));
            run_access(kind == 1, kind == 2, wb, alu, val, dest, stall, data, wbo_d, rdo_d, bad);
            if (kind == 0) begin
                chk($sformatf("rnd%0d_nonmem_stall", t), 32'(stall), 32'd0);
                chk($sformatf("rnd%0d_nonmem_alu", t), alu_o, alu);
                chk($sformatf("rnd%0d_nonmem_wbo", t), 32'(wbo_d), 32'(wb));
            end else begin
                chk($sformatf("rnd%0d_stall", t), 32'(stall), 32'(2 * W));
                chk($sformatf("rnd%0d_gate", t), 32'(bad), 32'd0);
                chk($sformatf("rnd%0d_wbo_done", t), 32'(wbo_d), 32'(wb));
                chk($sformatf("rnd%0d_rdo_done", t), 32'(rdo_d), 32'(kind == 1));
                if (kind == 1) begin
                    chk($sformatf("rnd%0d_load_data", t), data, ref_mem[idx]);
                end else begin
                    ref_mem[idx] = val;
                end
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
        @(negedge clk);
        for (int w = 16; w < 64; w++) begin
            chk($sformatf("mem_word[%0d]", w), {sram[2*w+1], sram[2*w]}, ref_mem[w]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
